// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack port between the fetch stage (master) and memory (slave).
`timescale 1ns/1ps
interface if_fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // Handshake: inst_req/inst_addr hold steady until the cycle inst_addr_ok is high;
  // that edge accepts the request, and exactly one inst_data_ok/inst_rdata follows later.
  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC/next-PC selection, request/ack imem port,
// IF/ID register with stall, flush and a one-entry skid buffer.
`timescale 1ns/1ps
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             exception,
  input  logic             EPC_sel,
  input  logic [31:0]      EPC,
  input  logic             jump_reg,
  input  logic [31:0]      PCSrc_reg,
  input  logic             branch_taken,
  input  logic [31:0]      jump_addr,
  if_fetch_stage_if.master imem,
  output logic [31:0]      instr,
  output logic [31:0]      pc_plus_4,
  output logic             if_valid,
  output logic             adel,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, addr_q, addr_nx;
  logic [31:0] instr_nx, pc4_nx;
  logic        valid_nx, adel_nx;
  logic        buf_valid, buf_valid_nx;
  logic [31:0] buf_instr, buf_instr_nx, buf_pc4, buf_pc4_nx;
  logic        discard, discard_nx;
  logic        pend_valid, pend_valid_nx;
  logic [31:0] pend_pc, pend_pc_nx;
  logic        redir;
  logic [31:0] target, pc_inc, npc;

  assign redir          = ~stall & (exception | EPC_sel | jump_reg | branch_taken);
  assign pc_inc         = pc + 32'd4;
  assign npc            = redir ? target : pc;
  assign imem.inst_req  = (state == REQ);
  assign imem.inst_addr = addr_q;
  assign dbg_state      = state;

  always_comb begin
    if (exception)    target = EXC_VECTOR;
    else if (EPC_sel) target = EPC;
    else if (jump_reg) target = PCSrc_reg;
    else              target = jump_addr;
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    addr_nx       = addr_q;
    instr_nx      = instr;
    pc4_nx        = pc_plus_4;
    valid_nx      = if_valid;
    adel_nx       = adel;
    buf_valid_nx  = buf_valid;
    buf_instr_nx  = buf_instr;
    buf_pc4_nx    = buf_pc4;
    discard_nx    = discard;
    pend_valid_nx = pend_valid;
    pend_pc_nx    = pend_pc;
    case (state)
      IDLE: begin
        if (!stall && buf_valid) begin
          instr_nx     = buf_instr;
          pc4_nx       = buf_pc4;
          valid_nx     = 1'b1;
          adel_nx      = 1'b0;
          buf_valid_nx = 1'b0;
          pc_nx        = npc;
        end else if (!stall) begin
          pc_nx = npc;
          if (npc[1:0] == 2'b00) begin
            state_nx = REQ;
            addr_nx  = npc;
          end else begin
            // Misaligned PC: no fetch, hand ID an address-error marker instead.
            instr_nx = '0;
            pc4_nx   = npc + 32'd4;
            valid_nx = 1'b1;
            adel_nx  = 1'b1;
          end
        end
      end
      REQ: begin
        // inst_addr is frozen for the handshake; a redirect waits in pend_pc.
        if (redir) begin
          pend_valid_nx = 1'b1;
          pend_pc_nx    = target;
        end
        if (imem.inst_addr_ok) begin
          state_nx      = WAIT;
          pend_valid_nx = 1'b0;
          if (redir)           pc_nx = target;
          else if (pend_valid) pc_nx = pend_pc;
          if (redir || pend_valid || flush) discard_nx = 1'b1;
        end
      end
      WAIT: begin
        pc_nx = npc;
        if (redir || flush) discard_nx = 1'b1;
        if (imem.inst_data_ok) begin
          if (discard || redir || flush) begin
            discard_nx = 1'b0;
            if (npc[1:0] == 2'b00) begin
              state_nx = REQ;
              addr_nx  = npc;
            end else begin
              state_nx = IDLE;
            end
          end else if (!stall) begin
            instr_nx = imem.inst_rdata;
            pc4_nx   = pc_inc;
            valid_nx = 1'b1;
            adel_nx  = 1'b0;
            pc_nx    = pc_inc;
            state_nx = REQ;
            addr_nx  = pc_inc;
          end else begin
            buf_valid_nx = 1'b1;
            buf_instr_nx = imem.inst_rdata;
            buf_pc4_nx   = pc_inc;
            pc_nx        = pc_inc;
            state_nx     = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Flush wins over any IF/ID or buffer load made above.
    if (flush) begin
      instr_nx     = '0;
      valid_nx     = 1'b0;
      adel_nx      = 1'b0;
      buf_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      instr      <= '0;
      pc_plus_4  <= '0;
      if_valid   <= 1'b0;
      adel       <= 1'b0;
      buf_valid  <= 1'b0;
      buf_instr  <= '0;
      buf_pc4    <= '0;
      discard    <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      addr_q     <= addr_nx;
      instr      <= instr_nx;
      pc_plus_4  <= pc4_nx;
      if_valid   <= valid_nx;
      adel       <= adel_nx;
      buf_valid  <= buf_valid_nx;
      buf_instr  <= buf_instr_nx;
      buf_pc4    <= buf_pc4_nx;
      discard    <= discard_nx;
      pend_valid <= pend_valid_nx;
      pend_pc    <= pend_pc_nx;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory responder, fetch/IF-ID scoreboards, final report.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, exception, EPC_sel, jump_reg, branch_taken;
  logic [31:0] EPC, PCSrc_reg, jump_addr;
  logic [31:0] instr, pc_plus_4;
  logic        if_valid, adel;
  logic [1:0]  dbg_state;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .exception(exception), .EPC_sel(EPC_sel), .EPC(EPC),
    .jump_reg(jump_reg), .PCSrc_reg(PCSrc_reg),
    .branch_taken(branch_taken), .jump_addr(jump_addr),
    .imem(bus),
    .instr(instr), .pc_plus_4(pc_plus_4), .if_valid(if_valid), .adel(adel),
    .dbg_state(dbg_state)
  );

  // Memory model: word at address a is {a[15:0], a[31:16]}, one special word.
  logic        ok_en, data_en, mem_pend;
  logic [31:0] mem_addr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h80000040) return 32'h24020005;
    return {a[15:0], a[31:16]};
  endfunction

  assign bus.inst_addr_ok = bus.inst_req & ok_en;
  assign bus.inst_data_ok = mem_pend & data_en;
  assign bus.inst_rdata   = word_at(mem_addr);

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_addr <= '0;
    end else if (bus.inst_req && bus.inst_addr_ok) begin
      mem_pend <= 1'b1;
      mem_addr <= bus.inst_addr;
    end else if (bus.inst_data_ok) begin
      mem_pend <= 1'b0;
    end
  end

  // Scoreboard
  logic [31:0] exp_addr_q[$];
  logic [64:0] exp_id_q[$];   // {adel, instr, pc_plus_4}
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_unexpected(input string name, input logic [71:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Monitor: each accepted fetch request
  always @(negedge clk) begin
    if (!rst && bus.inst_req && bus.inst_addr_ok) begin
      if (exp_addr_q.size() == 0) note_unexpected("fetch_addr", {40'd0, bus.inst_addr});
      else check("fetch_addr", {40'd0, bus.inst_addr}, {40'd0, exp_addr_q.pop_front()});
    end
  end

  // Monitor: each new valid IF/ID entry
  logic [65:0] id_snap, id_prev;
  assign id_snap = {if_valid, adel, instr, pc_plus_4};

  always @(negedge clk) begin
    if (rst) begin
      id_prev <= '0;
    end else begin
      id_prev <= id_snap;
      if (id_snap[65] && id_snap != id_prev) begin
        if (exp_id_q.size() == 0) note_unexpected("id_entry", {7'd0, id_snap[64:0]});
        else check("id_entry", {7'd0, id_snap[64:0]}, {7'd0, exp_id_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(bus.inst_req && bus.inst_addr == a) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!(bus.inst_req && bus.inst_addr == a)) begin
      errors++;
      $display("FAIL wait_req: no request for %h within 40 cycles, last addr %h", a, bus.inst_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; exception = 1'b0; EPC_sel = 1'b0;
    jump_reg = 1'b0; branch_taken = 1'b0; EPC = '0; PCSrc_reg = '0; jump_addr = '0;
    ok_en = 1'b1; data_en = 1'b1;
    repeat (3) tick();

    // Reset values
    check("rst_req", {71'd0, bus.inst_req}, 72'd0);
    check("rst_addr", {40'd0, bus.inst_addr}, {40'd0, 32'hBFC00000});
    check("rst_ifid", {6'd0, if_valid, adel, instr, pc_plus_4}, 72'd0);

    // Sequential fetch with zero-wait memory
    exp_addr_q.push_back(32'hBFC00000);
    exp_addr_q.push_back(32'hBFC00004);
    exp_addr_q.push_back(32'hBFC00008);
    exp_addr_q.push_back(32'hBFC0000C);
    exp_id_q.push_back({1'b0, 32'h0000BFC0, 32'hBFC00004});
    exp_id_q.push_back({1'b0, 32'h0004BFC0, 32'hBFC00008});
    exp_id_q.push_back({1'b0, 32'h0008BFC0, 32'hBFC0000C});
    rst = 1'b0;
    tick();
    check("first_req", {39'd0, bus.inst_req, bus.inst_addr}, {39'd0, 1'b1, 32'hBFC00000});
    wait_req(32'hBFC0000C);
    data_en = 1'b0;
    tick();

    // Branch in WAIT: returned word dropped
    exp_addr_q.push_back(32'hBFC00100);
    branch_taken = 1'b1; jump_addr = 32'hBFC00100;
    tick();
    branch_taken = 1'b0; data_en = 1'b1;
    tick();
    check("branch_drop", {39'd0, if_valid, instr}, {39'd0, 1'b1, 32'h0008BFC0});
    wait_req(32'hBFC00100);

    // All redirects together: exception wins
    exp_addr_q.push_back(32'hBFC00380);
    data_en = 1'b0;
    tick();
    exception = 1'b1; jump_reg = 1'b1; branch_taken = 1'b1; PCSrc_reg = 32'h80000040;
    tick();
    exception = 1'b0; jump_reg = 1'b0; branch_taken = 1'b0; data_en = 1'b1;
    tick();
    wait_req(32'hBFC00380);

    // addr_ok withheld while jump_reg is high: address holds, request is discarded
    exp_addr_q.push_back(32'h80000040);
    ok_en = 1'b0; jump_reg = 1'b1; PCSrc_reg = 32'h80000040;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("req_hold", {39'd0, bus.inst_req, bus.inst_addr}, {39'd0, 1'b1, 32'hBFC00380});
    end
    jump_reg = 1'b0; ok_en = 1'b1;
    tick();
    tick();
    wait_req(32'h80000040);

    // Stall when data returns: skid buffer
    exp_id_q.push_back({1'b0, 32'h24020005, 32'h80000044});
    data_en = 1'b0;
    tick();
    stall = 1'b1; data_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stall_no_req", {71'd0, bus.inst_req}, 72'd0);
      check("stall_hold", {40'd0, instr}, {40'd0, 32'h0008BFC0});
      tick();
    end
    ok_en = 1'b0; stall = 1'b0;
    tick();
    check("skid_out", {8'd0, instr, pc_plus_4}, {8'd0, 32'h24020005, 32'h80000044});
    tick();
    check("after_skid_req", {39'd0, bus.inst_req, bus.inst_addr}, {39'd0, 1'b1, 32'h80000044});

    // ERET to misaligned EPC: address-error entry, no request
    exp_addr_q.push_back(32'h80000044);
    exp_id_q.push_back({1'b1, 32'h00000000, 32'h80000006});
    EPC_sel = 1'b1; EPC = 32'h80000002;
    tick();
    EPC_sel = 1'b0; ok_en = 1'b1;
    tick();
    tick();
    tick();
    check("adel_entry", {37'd0, if_valid, adel, instr, 1'b0}, {37'd0, 1'b1, 1'b1, 32'h0, 1'b0});
    check("adel_pc4", {40'd0, pc_plus_4}, {40'd0, 32'h80000006});
    for (int i = 0; i < 3; i++) begin
      check("adel_no_req", {71'd0, bus.inst_req}, 72'd0);
      tick();
    end

    // Flush together with data_ok, then flush of a buffered instruction
    exp_addr_q.push_back(32'hBFC00200);
    exp_addr_q.push_back(32'hBFC00200);
    exp_addr_q.push_back(32'hBFC00204);
    exp_id_q.push_back({1'b0, 32'h0204BFC0, 32'hBFC00208});
    branch_taken = 1'b1; jump_addr = 32'hBFC00200; data_en = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("redir_idle_req", {39'd0, bus.inst_req, bus.inst_addr}, {39'd0, 1'b1, 32'hBFC00200});
    tick();
    flush = 1'b1; data_en = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_clear", {38'd0, if_valid, adel, instr}, 72'd0);
    data_en = 1'b0;
    tick();
    stall = 1'b1; data_en = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    tick();
    check("flush_buf", {38'd0, bus.inst_req, if_valid, bus.inst_addr}, {38'd0, 1'b1, 1'b0, 32'hBFC00204});
    tick();
    ok_en = 1'b0;
    tick();
    check("post_flush_fetch", {8'd0, instr, pc_plus_4}, {8'd0, 32'h0204BFC0, 32'hBFC00208});

    // PC+4 wraps at the top of the address space
    exp_addr_q.push_back(32'hBFC00208);
    exp_addr_q.push_back(32'hFFFFFFFC);
    exp_id_q.push_back({1'b0, 32'hFFFCFFFF, 32'h00000000});
    jump_reg = 1'b1; PCSrc_reg = 32'hFFFFFFFC;
    tick();
    jump_reg = 1'b0; ok_en = 1'b1;
    tick();
    tick();
    wait_req(32'hFFFFFFFC);
    tick();
    tick();
    ok_en = 1'b0;
    check("wrap_pc4", {40'd0, pc_plus_4}, 72'd0);
    check("wrap_req", {39'd0, bus.inst_req, bus.inst_addr}, {39'd0, 1'b1, 32'h00000000});

    repeat (4) tick();
    check("addr_q_empty", {40'd0, 32'(exp_addr_q.size())}, 72'd0);
    check("id_q_empty", {40'd0, 32'(exp_id_q.size())}, 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID stage.
- Owns the PC register and next-PC selection: sequential, branch/jump, jump-register, ERET/EPC, exception vector.
- Drives a request/ack instruction-memory port and holds the IF/ID pipeline register (instr, pc_plus_4) with stall, flush and a one-entry skid buffer.

Parameters:
RESET_PC  32'hBFC00000  PC loaded on reset
EXC_VECTOR  32'hBFC00380  target when exception asserted

Ports:
clk  in  1  system clock
rst  in  1  reset
stall  in  1  hazard unit: hold IF/ID and PC
flush  in  1  ID CLR_EN: squash IF/ID contents
exception  in  1  redirect to EXC_VECTOR
EPC_sel  in  1  ERET: redirect to EPC
EPC  in  32  return address
jump_reg  in  1  JR/JALR: redirect to PCSrc_reg
PCSrc_reg  in  32  register jump target
branch_taken  in  1  taken branch or J/JAL: redirect to jump_addr
jump_addr  in  32  PC-relative/absolute target from ID
inst_req  out  1  memory request valid
inst_addr  out  32  fetch address
inst_addr_ok  in  1  request accepted
inst_data_ok  in  1  read data valid
inst_rdata  in  32  fetched word
instr  out  32  IF/ID instruction
pc_plus_4  out  32  IF/ID PC+4
if_valid  out  1  IF/ID holds a real instruction
adel  out  1  IF/ID entry is a misaligned-fetch fault

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. All state changes occur on the rising edge of clk.
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - inst_req=0, inst_addr=RESET_PC.
  - instr=0, pc_plus_4=0, if_valid=0, adel=0.
  - buf_valid=0, discard=0, pend_valid=0.
- Reset mid-transaction abandons the transaction; a late inst_data_ok after reset is ignored.
- Redirect: redir = exception|EPC_sel|jump_reg|branch_taken, sampled only when stall=0.
- Target priority is exception > EPC_sel > jump_reg > branch_taken:
  - exception -> EXC_VECTOR
  - EPC_sel -> EPC
  - jump_reg -> PCSrc_reg
  - branch_taken -> jump_addr
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If buf_valid=0, stall=0 and pc[1:0]==0: go to REQ next cycle with inst_req=1 and inst_addr=pc.
  - If pc[1:0]!=0: no request is issued. Load IF/ID with instr=0, adel=1, if_valid=1, pc_plus_4=pc+4. Stay in IDLE until a redirect.
- REQ:
  - inst_req=1; inst_addr stays stable until inst_addr_ok.
  - On inst_addr_ok: go to WAIT; inst_req=0 from the next cycle.
  - A redirect in REQ is latched into pend_valid/pend_pc. It must not alter inst_addr mid-handshake. discard is set when addr_ok arrives.
- WAIT:
  - A redirect sets discard=1 and loads pc=target. If pend_valid is set, apply pend_pc to pc and set discard.
  - On inst_data_ok with discard=1: drop the data, clear discard, go to REQ at the new pc.
  - On inst_data_ok with discard=0 and stall=0: IF/ID <= {inst_rdata, pc+4}, if_valid=1, adel=0; pc<=pc+4; go to REQ.
  - On inst_data_ok with discard=0 and stall=1: capture into the skid buffer (buf_valid=1), pc<=pc+4, go to IDLE.
- Skid buffer: when stall drops with buf_valid=1, the buffer moves to IF/ID that cycle; buf_valid=0; the next request issues the following cycle.
- Stall: IF/ID, pc and buffer hold. An outstanding WAIT still completes into the buffer.
- Flush (priority over any IF/ID write in the same cycle):
  - instr=0, if_valid=0, adel=0.
  - buf_valid=0.
  - An in-flight non-discarded fetch is marked discard unless a redirect already set it.
- Flush with stall=1: the flush still applies.
- Redirect with no transaction in flight (IDLE): pc=target; issue from the new pc next cycle.
- Width rules:
  - pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
  - pc_plus_4 = fetched pc + 4.
- Best-case throughput is one instruction per 2 cycles, with addr_ok in the REQ cycle and data_ok the following cycle.

Test Plan:
- Reset with zero-wait memory, rst held 3 cycles then released -> first inst_req=1 with inst_addr=32'hBFC00000 one cycle after release. Sequential addresses BFC00000, BFC00004, BFC00008; pc_plus_4 = addr+4; if_valid=1.
- branch_taken=1, jump_addr=32'hBFC00100 asserted in WAIT -> returned word dropped (if_valid unchanged). Next inst_addr=BFC00100. With exception and jump_reg also high -> next inst_addr=BFC00380.
- inst_addr_ok withheld 4 cycles while jump_reg=1, PCSrc_reg=32'h80000040 -> inst_addr stable during REQ. Data for that request discarded; next request at 80000040.
- stall=1 when data_ok returns instr 32'h24020005 -> IF/ID unchanged, no new inst_req. When stall drops, instr=24020005 appears next edge, then the next request issues.
- EPC_sel=1, EPC=32'h80000002 -> no inst_req; IF/ID instr=0, adel=1, if_valid=1, pc_plus_4=80000006.
- flush=1 together with a data_ok in the same cycle -> if_valid=0, instr=0; buffered instruction discarded.
